// File: rtl/stopwatch_bcd.sv
// MM:SS BCD stopwatch with start/pause/clear control and seven-segment drive.
// A divided clock is rising-edge detected in the clk domain and qualifies counting.
module stopwatch_bcd #(
  parameter int MAX_MIN        = 59,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       btn_start,
  input  logic       btn_clear,
  output logic       running,
  output logic       wrap,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic [6:0] seg0,
  output logic [6:0] seg1,
  output logic [6:0] seg2,
  output logic [6:0] seg3
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;

  localparam logic [3:0] MAX_TENS = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_ONES = 4'(MAX_MIN % 10);
  localparam logic [6:0] SEG_MASK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  state_t     state_r, state_nxt_s;
  logic       tick_q_r;
  logic       start_meta_r, start_sync_r, start_edge_r;
  logic       clear_meta_r, clear_sync_r, clear_edge_r;
  logic       tick_rise_s, start_ev_s, clear_ev_s, count_en_s, wrap_nxt_s;
  logic [3:0] so_nxt_s, st_nxt_s, mo_nxt_s, mt_nxt_s;

  // Active-high segment pattern {g,f,e,d,c,b,a}; non-BCD codes blank the digit.
  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'b0111111;
      4'd1:    p = 7'b0000110;
      4'd2:    p = 7'b1011011;
      4'd3:    p = 7'b1001111;
      4'd4:    p = 7'b1100110;
      4'd5:    p = 7'b1101101;
      4'd6:    p = 7'b1111101;
      4'd7:    p = 7'b0000111;
      4'd8:    p = 7'b1111111;
      4'd9:    p = 7'b1101111;
      default: p = 7'b0000000;
    endcase
    return p;
  endfunction

  assign tick_rise_s = tick_in & ~tick_q_r;
  assign start_ev_s  = start_sync_r & ~start_edge_r;
  assign clear_ev_s  = clear_sync_r & ~clear_edge_r;

  // Tick edge register and button synchronisers; tick_q resets high so a held tick is ignored.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tick_q_r     <= 1'b1;
      start_meta_r <= 1'b0;
      start_sync_r <= 1'b0;
      start_edge_r <= 1'b0;
      clear_meta_r <= 1'b0;
      clear_sync_r <= 1'b0;
      clear_edge_r <= 1'b0;
    end else begin
      tick_q_r     <= tick_in;
      start_meta_r <= btn_start;
      start_sync_r <= start_meta_r;
      start_edge_r <= start_sync_r;
      clear_meta_r <= btn_clear;
      clear_sync_r <= clear_meta_r;
      clear_edge_r <= clear_sync_r;
    end
  end

  // Next state and count enable; a tick only counts when the current state is RUN.
  always_comb begin
    state_nxt_s = state_r;
    count_en_s  = 1'b0;
    if (clear_ev_s) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_nxt_s = start_ev_s ? RUN : IDLE;
        RUN: begin
          count_en_s  = tick_rise_s;
          state_nxt_s = start_ev_s ? PAUSE : RUN;
        end
        PAUSE:   state_nxt_s = start_ev_s ? RUN : PAUSE;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // BCD increment with carry chain; minutes wrap to zero after MAX_MIN:59.
  always_comb begin
    so_nxt_s   = sec_ones;
    st_nxt_s   = sec_tens;
    mo_nxt_s   = min_ones;
    mt_nxt_s   = min_tens;
    wrap_nxt_s = 1'b0;
    if (sec_ones != 4'd9) begin
      so_nxt_s = sec_ones + 4'd1;
    end else begin
      so_nxt_s = 4'd0;
      if (sec_tens != 4'd5) begin
        st_nxt_s = sec_tens + 4'd1;
      end else begin
        st_nxt_s = 4'd0;
        if ((min_tens == MAX_TENS) && (min_ones == MAX_ONES)) begin
          mo_nxt_s   = 4'd0;
          mt_nxt_s   = 4'd0;
          wrap_nxt_s = 1'b1;
        end else if (min_ones != 4'd9) begin
          mo_nxt_s = min_ones + 4'd1;
        end else begin
          mo_nxt_s = 4'd0;
          mt_nxt_s = min_tens + 4'd1;
        end
      end
    end
  end

  // State, registered status outputs and BCD count; clear discards a coincident tick.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r  <= IDLE;
      running  <= 1'b0;
      wrap     <= 1'b0;
      sec_ones <= 4'd0;
      sec_tens <= 4'd0;
      min_ones <= 4'd0;
      min_tens <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      running <= (state_nxt_s == RUN);
      wrap    <= 1'b0;
      if (clear_ev_s) begin
        sec_ones <= 4'd0;
        sec_tens <= 4'd0;
        min_ones <= 4'd0;
        min_tens <= 4'd0;
      end else if (count_en_s) begin
        sec_ones <= so_nxt_s;
        sec_tens <= st_nxt_s;
        min_ones <= mo_nxt_s;
        min_tens <= mt_nxt_s;
        wrap     <= wrap_nxt_s;
      end
    end
  end

  assign seg0 = seg_encode(sec_ones) ^ SEG_MASK;
  assign seg1 = seg_encode(sec_tens) ^ SEG_MASK;
  assign seg2 = seg_encode(min_ones) ^ SEG_MASK;
  assign seg3 = seg_encode(min_tens) ^ SEG_MASK;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Directed self-checking bench: a default instance (59 min, active-low segments)
// and a short-wrap instance (5 min, active-high) share all stimulus.
module tb_stopwatch_bcd;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tick_in = 1'b0;
  logic btn_start = 1'b0;
  logic btn_clear = 1'b0;

  logic       running, wrap, running5, wrap5;
  logic [3:0] so, st, mo, mt, so5, st5, mo5, mt5;
  logic [6:0] s0, s1, s2, s3, s05, s15, s25, s35;

  int checks = 0;
  int errors = 0;
  int secs = 0;
  logic w59, w5;

  always #5 clk = ~clk;

  stopwatch_bcd #(.MAX_MIN(59), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset(reset), .tick_in(tick_in), .btn_start(btn_start), .btn_clear(btn_clear),
    .running(running), .wrap(wrap), .sec_ones(so), .sec_tens(st), .min_ones(mo), .min_tens(mt),
    .seg0(s0), .seg1(s1), .seg2(s2), .seg3(s3));

  stopwatch_bcd #(.MAX_MIN(5), .SEG_ACTIVE_LOW(1'b0)) dut5 (
    .clk(clk), .reset(reset), .tick_in(tick_in), .btn_start(btn_start), .btn_clear(btn_clear),
    .running(running5), .wrap(wrap5), .sec_ones(so5), .sec_tens(st5), .min_ones(mo5), .min_tens(mt5),
    .seg0(s05), .seg1(s15), .seg2(s25), .seg3(s35));

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] bcd_of(input int s);
    int m, x;
    m = s / 60;
    x = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // One tick_in rising edge; wrap is captured right after the counting edge.
  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_in = 1'b1;
      step();
      w59 = wrap;
      w5  = wrap5;
      tick_in = 1'b0;
      step();
    end
  endtask

  task automatic press_start();
    btn_start = 1'b1;
    steps(3);
    btn_start = 1'b0;
    steps(3);
  endtask

  task automatic check_time(input string tag, input int s);
    check_val({tag, "_bcd59"}, {mt, mo, st, so}, bcd_of(s % 3600));
    check_val({tag, "_bcd5"}, {mt5, mo5, st5, so5}, bcd_of(s % 360));
  endtask

  initial begin
    // Reset with tick_in held high, then release while it stays high.
    tick_in = 1'b1;
    steps(3);
    reset = 1'b1;
    steps(3);
    check_time("reset", 0);
    check_val("reset_seg", {s3, s2, s1, s0}, {4{7'b1000000}});
    check_val("reset_seg5", {s35, s25, s15, s05}, {4{7'b0111111}});
    check_val("reset_running", running, 1'b0);
    check_val("reset_wrap", wrap, 1'b0);
    tick_in = 1'b0;
    step();
    check_time("held_tick", 0);

    // Start: running rises on the 3rd edge after the button.
    btn_start = 1'b1;
    steps(2);
    check_val("start_lat2", running, 1'b0);
    step();
    check_val("start_lat3", running, 1'b1);
    btn_start = 1'b0;
    steps(3);
    do_ticks(5);
    secs = 5;
    check_time("five", secs);
    check_val("five_seg0", s0, 7'b0010010);
    check_val("five_seg0_hi", s05, 7'b1101101);

    do_ticks(54);
    secs = 59;
    check_time("sec59", secs);
    do_ticks(1);
    secs = 60;
    check_time("min1", secs);
    check_val("min1_wrap", w59, 1'b0);

    // Short-wrap instance rolls after 05:59.
    do_ticks(299);
    secs = 359;
    check_time("t0559", secs);
    do_ticks(1);
    secs = 360;
    check_time("wrap5", secs);
    check_val("wrap5_pulse", w5, 1'b1);
    check_val("wrap5_not59", w59, 1'b0);
    check_val("wrap5_gone", wrap5, 1'b0);
    check_val("wrap5_running", running5, 1'b1);

    do_ticks(3239);
    secs = 3599;
    check_time("t5959", secs);
    check_val("t5959_seg", {s3, s2, s1, s0}, {7'b0010010, 7'b0010000, 7'b0010010, 7'b0010000});
    do_ticks(1);
    secs = 0;
    check_time("wrap59", secs);
    check_val("wrap59_pulse", w59, 1'b1);
    check_val("wrap59_gone", wrap, 1'b0);
    check_val("wrap59_running", running, 1'b1);

    // Pause and resume.
    do_ticks(3);
    secs = 3;
    press_start();
    check_val("pause_running", running, 1'b0);
    do_ticks(4);
    check_time("paused", secs);
    press_start();
    check_val("resume_running", running, 1'b1);
    do_ticks(2);
    secs = 5;
    check_time("resumed", secs);

    // Start event coincident with tick in RUN: counted, then PAUSE.
    btn_start = 1'b1;
    steps(2);
    tick_in = 1'b1;
    step();
    secs = 6;
    check_time("start_tick_run", secs);
    check_val("start_tick_run_state", running, 1'b0);
    tick_in = 1'b0;
    btn_start = 1'b0;
    steps(3);

    // Start event coincident with tick in PAUSE: not counted, then RUN.
    btn_start = 1'b1;
    steps(2);
    tick_in = 1'b1;
    step();
    check_time("start_tick_pause", secs);
    check_val("start_tick_pause_state", running, 1'b1);
    tick_in = 1'b0;
    btn_start = 1'b0;
    steps(3);

    do_ticks(748);
    secs = 754;
    check_time("t1234", secs);
    check_val("t1234_seg", {s3, s2, s1, s0}, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});

    // Clear coincident with tick: count zeroed, tick discarded, IDLE.
    btn_clear = 1'b1;
    steps(2);
    tick_in = 1'b1;
    step();
    secs = 0;
    check_time("clear", secs);
    check_val("clear_running", running, 1'b0);
    check_val("clear_wrap", wrap, 1'b0);
    tick_in = 1'b0;
    btn_clear = 1'b0;
    steps(3);
    do_ticks(2);
    check_time("idle_tick", secs);

    // Reset mid-count.
    press_start();
    do_ticks(3);
    secs = 3;
    check_time("pre_reset", secs);
    reset = 1'b0;
    step();
    check_time("mid_reset", 0);
    check_val("mid_reset_running", running, 1'b0);
    reset = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
